// File: rtl/alu_sequencer.sv
// Instruction sequencer for a simple register-file/ALU datapath.
// Moore FSM: all outputs come from the current state and the latched instruction.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic [15:0] instr,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        vsel,
    output logic [15:0] sximm8,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GETA   = 3'd2,
        S_GETB   = 3'd3,
        S_ALU    = 3'd4,
        S_WRIMM  = 3'd5,
        S_WRREG  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic       is_alu, is_cmp;

    assign opc = ir_q[15:13];
    assign op  = ir_q[12:11];
    assign rn  = ir_q[10:8];
    assign rd  = ir_q[7:5];
    assign sh  = ir_q[4:3];
    assign rm  = ir_q[2:0];

    // ALU-class ops read A; MVN and MOV reg pass only the shifted B operand.
    assign is_alu = (opc == 3'b101) && (op != 2'b11);
    assign is_cmp = (opc == 3'b101) && (op == 2'b01);

    assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign busy   = (state_q != S_WAIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'd0;
        ALUop    = 2'd0;
        vsel     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (s) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opc == 3'b110 && op == 2'b10)      state_d = S_WRIMM;
                else if (opc == 3'b110 && op == 2'b00) state_d = S_GETB;
                else if (is_alu)                       state_d = S_GETA;
                else if (opc == 3'b101)                state_d = S_GETB;
                else begin
                    err     = 1'b1;
                    done    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_GETA: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GETB;
            end
            S_GETB: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                bsel  = 1'b0;
                shift = sh;
                asel  = is_alu;
                ALUop = (opc == 3'b101) ? op : 2'b00;
                if (is_cmp) begin
                    loads   = 1'b1;
                    done    = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WRREG;
                end
            end
            S_WRIMM: begin
                write    = 1'b1;
                vsel     = 1'b1;
                writenum = rn;
                done     = 1'b1;
                state_d  = S_WAIT;
            end
            S_WRREG: begin
                write    = 1'b1;
                writenum = rd;
                done     = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed, table-driven bench for alu_sequencer: per-cycle expected outputs
// for each instruction class, plus hand sequences for reset behaviour.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel, vsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm8;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n), .s(s), .instr(instr),
        .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .vsel(vsel),
        .sximm8(sximm8), .busy(busy), .done(done), .err(err)
    );

    // {readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, shift, ALUop, vsel, busy, done, err}
    function automatic logic [20:0] ev(input logic [2:0] rn, input logic [2:0] wn,
                                       input logic [4:0] strb, input logic as, input logic bs,
                                       input logic [1:0] sh, input logic [1:0] aop,
                                       input logic vs, input logic by, input logic dn,
                                       input logic er);
        return {rn, wn, strb, as, bs, sh, aop, vs, by, dn, er};
    endfunction

    function automatic logic [20:0] act();
        return {readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, shift, ALUop, vsel, busy, done, err};
    endfunction

    // strobe codes: {write, loada, loadb, loadc, loads}
    localparam logic [4:0] NONE = 5'b00000, WR = 5'b10000, LA = 5'b01000,
                           LB = 5'b00100, LC = 5'b00010, LS = 5'b00001;

    typedef struct {
        logic        go;
        logic [15:0] ins;
        logic [20:0] exp;
        logic [15:0] simm;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic go, input logic [15:0] ins,
                       input logic [20:0] exp, input logic [15:0] simm);
        vec_t v;
        v.go = go; v.ins = ins; v.exp = exp; v.simm = simm;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [20:0] a, input logic [20:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b", name, a, e);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] a, input logic [15:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: sximm8 got %h want %h", name, a, e);
        end
    endtask

    logic [20:0] idle, dec;

    initial begin
        idle = ev(0, 0, NONE, 0, 0, 0, 0, 0, 0, 0, 0);
        dec  = ev(0, 0, NONE, 0, 0, 0, 0, 0, 1, 0, 0);

        // MOV R2,#5; s held into the done cycle must not be accepted
        add(1, 16'hD205, dec, 16'h0005);
        add(0, 16'hFFFF, ev(0, 2, WR, 0, 0, 0, 0, 1, 1, 1, 0), 16'h0005);
        add(1, 16'hD2FB, idle, 16'h0005);
        // accepted on the following WAIT cycle
        add(1, 16'hD2FB, dec, 16'hFFFB);
        add(0, 16'h0000, ev(0, 2, WR, 0, 0, 0, 0, 1, 1, 1, 0), 16'hFFFB);
        add(0, 16'h0000, idle, 16'hFFFB);
        // ADD R2,R1,R2 LSL1 with a stray s during GETB
        add(1, 16'hA14A, dec, 16'h004A);
        add(0, 16'hFFFF, ev(1, 0, LA, 0, 0, 0, 0, 0, 1, 0, 0), 16'h004A);
        add(1, 16'h0000, ev(2, 0, LB, 0, 0, 0, 0, 0, 1, 0, 0), 16'h004A);
        add(1, 16'h0000, ev(0, 0, LC, 1, 0, 1, 0, 0, 1, 0, 0), 16'h004A);
        add(0, 16'h0000, ev(0, 2, WR, 0, 0, 0, 0, 0, 1, 1, 0), 16'h004A);
        add(0, 16'h0000, idle, 16'h004A);
        // CMP R1,R0
        add(1, 16'hA900, dec, 16'h0000);
        add(0, 16'hFFFF, ev(1, 0, LA, 0, 0, 0, 0, 0, 1, 0, 0), 16'h0000);
        add(0, 16'hFFFF, ev(0, 0, LB, 0, 0, 0, 0, 0, 1, 0, 0), 16'h0000);
        add(0, 16'hFFFF, ev(0, 0, LS, 1, 0, 0, 1, 0, 1, 1, 0), 16'h0000);
        add(0, 16'hFFFF, idle, 16'h0000);
        // MOV R3,R5 LSR-type shift 10
        add(1, 16'hC075, dec, 16'h0075);
        add(0, 16'h0000, ev(5, 0, LB, 0, 0, 0, 0, 0, 1, 0, 0), 16'h0075);
        add(0, 16'h0000, ev(0, 0, LC, 0, 0, 2, 0, 0, 1, 0, 0), 16'h0075);
        add(0, 16'h0000, ev(0, 3, WR, 0, 0, 0, 0, 0, 1, 1, 0), 16'h0075);
        add(0, 16'h0000, idle, 16'h0075);
        // MVN R4,R1 shift 11
        add(1, 16'hB899, dec, 16'hFF99);
        add(0, 16'h0000, ev(1, 0, LB, 0, 0, 0, 0, 0, 1, 0, 0), 16'hFF99);
        add(0, 16'h0000, ev(0, 0, LC, 0, 0, 3, 3, 0, 1, 0, 0), 16'hFF99);
        add(0, 16'h0000, ev(0, 4, WR, 0, 0, 0, 0, 0, 1, 1, 0), 16'hFF99);
        add(0, 16'h0000, idle, 16'hFF99);
        // AND R6,R3,R7
        add(1, 16'hB3C7, dec, 16'hFFC7);
        add(0, 16'h0000, ev(3, 0, LA, 0, 0, 0, 0, 0, 1, 0, 0), 16'hFFC7);
        add(0, 16'h0000, ev(7, 0, LB, 0, 0, 0, 0, 0, 1, 0, 0), 16'hFFC7);
        add(0, 16'h0000, ev(0, 0, LC, 1, 0, 0, 2, 0, 1, 0, 0), 16'hFFC7);
        add(0, 16'h0000, ev(0, 6, WR, 0, 0, 0, 0, 0, 1, 1, 0), 16'hFFC7);
        add(0, 16'h0000, idle, 16'hFFC7);
        // illegal encodings: err+done in DECODE, then straight back to WAIT
        add(1, 16'h0000, ev(0, 0, NONE, 0, 0, 0, 0, 0, 1, 1, 1), 16'h0000);
        add(0, 16'h0000, idle, 16'h0000);
        add(1, 16'hC800, ev(0, 0, NONE, 0, 0, 0, 0, 0, 1, 1, 1), 16'h0000);
        add(1, 16'hE0AA, idle, 16'h0000);
        add(1, 16'hE0AA, ev(0, 0, NONE, 0, 0, 0, 0, 0, 1, 1, 1), 16'hFFAA);
        add(0, 16'h0000, idle, 16'hFFAA);

        #2;
        chk("reset_outputs", act(), idle);
        chk16("reset_sximm8", sximm8, 16'h0000);

        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            s     = vecs[i].go;
            instr = vecs[i].ins;
            @(posedge clk);
            #1;
            chk($sformatf("vec[%0d]", i), act(), vecs[i].exp);
            chk16($sformatf("vec[%0d]", i), sximm8, vecs[i].simm);
        end

        // reset asserted during GETB of an ADD
        @(negedge clk); s = 1'b1; instr = 16'hA14A;
        @(negedge clk); s = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_geta", act(), ev(1, 0, LA, 0, 0, 0, 0, 0, 1, 0, 0));
        @(posedge clk); #1;
        chk("rst_pre_getb", act(), ev(2, 0, LB, 0, 0, 0, 0, 0, 1, 0, 0));
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async", act(), idle);
        chk16("rst_async", sximm8, 16'h0000);
        @(negedge clk); s = 1'b1; instr = 16'hD205;
        @(posedge clk); #1;
        chk("rst_held", act(), idle);
        @(negedge clk); reset_n = 1'b1; s = 1'b0;
        @(posedge clk); #1;
        chk("rst_released_idle", act(), idle);
        @(negedge clk); s = 1'b1; instr = 16'hD205;
        @(posedge clk); #1;
        chk("post_rst_decode", act(), dec);
        @(negedge clk); s = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_wrimm", act(), ev(0, 2, WR, 0, 0, 0, 0, 1, 1, 1, 0));
        chk16("post_rst_wrimm", sximm8, 16'h0005);
        @(posedge clk); #1;
        chk("post_rst_wait", act(), idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
